// File: rtl/ioports_param.sv
// ioports_param - parametrised general-purpose I/O port bank behind the
// 8-bit byte-serial host command link.
//
// Optional feature macro: IOPORTS_BURST_EN
//   defined     -> opcode 3'b100 (BURST) and state WCOUNT are built
//   not defined -> opcode 3'b100 is ignored like any unknown opcode
//
// Ports:
//   clk      in  1            master clock, single domain
//   reset    in  1            synchronous active-high master reset
//   load     in  1            datain valid, one byte per cycle
//   datain   in  8            command/data byte
//   ready    in  1            host ready to accept a dataout byte
//   enout    out 1            dataout valid (registered)
//   dataout  out 8            read data byte (registered)
//   in_bus   in  N_IN*W       input ports, port k at [k*W +: W]
//   out_bus  out N_OUT*W      output port registers, port k at [k*W +: W]
//
// Command byte (IDLE, load=1): opcode datain[6:4], address datain[3:0]
//   001 RESET, 010 WRITE, 011 READ, 100 BURST (macro only), others ignored.
// Data words travel most-significant byte first.

module ioports_param #(
    parameter int                           N_OUT      = 16,
    parameter int                           N_IN       = 8,
    parameter int                           NBYTES     = 4,
    parameter logic [N_OUT*8*NBYTES-1:0]    INIT_OUT   = '0,
    parameter logic [15:0]                  PULSE_MASK = 16'h8000,
    parameter int                           PULSE_LEN  = 4,
    parameter logic [31:0]                  HWID       = 32'h2018_1702
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        load,
    input  logic [7:0]                  datain,
    input  logic                        ready,
    output logic                        enout,
    output logic [7:0]                  dataout,
    input  logic [N_IN*8*NBYTES-1:0]    in_bus,
    output logic [N_OUT*8*NBYTES-1:0]   out_bus
);

    localparam int             W      = 8 * NBYTES;
    localparam logic [2:0]     NB_IDX = 3'(NBYTES - 1);
    localparam logic [W-1:0]   HWID_W = W'(HWID);
    localparam logic [7:0]     PLEN   = 8'(PULSE_LEN);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
`ifdef IOPORTS_BURST_EN
        ST_WCOUNT = 3'd1,
`endif
        ST_WBYTE  = 3'd2,
        ST_RSEND  = 3'd3,
        ST_RWAIT  = 3'd4
    } state_t;

    state_t             state_r, state_nx_s;
    logic [3:0]         addr_r, addr_nx_s;
    logic [2:0]         idx_r, idx_nx_s;
    logic [W-1:0]       acc_r, acc_nx_s;
    logic [W-1:0]       shift_r, shift_nx_s;
    logic               enout_r, enout_nx_s;
    logic [7:0]         dataout_r, dataout_nx_s;
    logic [N_OUT*W-1:0] out_r;
    logic [7:0]         cnt_r [N_OUT];
`ifdef IOPORTS_BURST_EN
    logic [7:0]         bcnt_r, bcnt_nx_s;
`endif

    logic [W-1:0]       word_s;
    logic [W-1:0]       snap_s;
    logic               wr_s;
    logic               clr_s;

    assign out_bus = out_r;
    assign enout   = enout_r;
    assign dataout = dataout_r;

    // Word assembled from the accumulated upper bytes and the byte on datain.
    always_comb begin
        word_s = W'({acc_r, datain});
    end

    // Read snapshot source: addressed input port, or the hardware ID when the
    // address names a nonexistent input port.
    always_comb begin
        snap_s = HWID_W;
        for (int k = 0; k < N_IN; k++) begin
            snap_s = (datain[3:0] == 4'(k)) ? in_bus[k*W +: W] : snap_s;
        end
    end

    // Next-state and next-value logic for the command FSM and read handshake.
    always_comb begin
        state_nx_s   = state_r;
        addr_nx_s    = addr_r;
        idx_nx_s     = idx_r;
        acc_nx_s     = acc_r;
        shift_nx_s   = shift_r;
        enout_nx_s   = enout_r;
        dataout_nx_s = dataout_r;
        wr_s         = 1'b0;
        clr_s        = 1'b0;
`ifdef IOPORTS_BURST_EN
        bcnt_nx_s    = bcnt_r;
`endif
        case (state_r)
            ST_IDLE: begin
                if (load) begin
                    case (datain[6:4])
                        3'b001: begin
                            clr_s      = 1'b1;
                            enout_nx_s = 1'b0;
                        end
                        3'b010: begin
                            addr_nx_s  = datain[3:0];
                            idx_nx_s   = NB_IDX;
                            acc_nx_s   = '0;
`ifdef IOPORTS_BURST_EN
                            bcnt_nx_s  = 8'd1;
`endif
                            state_nx_s = ST_WBYTE;
                        end
                        3'b011: begin
                            shift_nx_s = snap_s;
                            idx_nx_s   = NB_IDX;
                            state_nx_s = ST_RSEND;
                        end
`ifdef IOPORTS_BURST_EN
                        3'b100: begin
                            addr_nx_s  = datain[3:0];
                            state_nx_s = ST_WCOUNT;
                        end
`endif
                        default: begin
                            state_nx_s = ST_IDLE;
                        end
                    endcase
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
`ifdef IOPORTS_BURST_EN
            ST_WCOUNT: begin
                if (load) begin
                    // A zero count still transfers one word.
                    bcnt_nx_s  = (datain == 8'd0) ? 8'd1 : datain;
                    idx_nx_s   = NB_IDX;
                    acc_nx_s   = '0;
                    state_nx_s = ST_WBYTE;
                end else begin
                    state_nx_s = ST_WCOUNT;
                end
            end
`endif
            ST_WBYTE: begin
                if (load) begin
                    acc_nx_s = word_s;
                    if (idx_r == 3'd0) begin
                        // Addresses beyond N_OUT match no port, so the word is dropped.
                        wr_s = 1'b1;
`ifdef IOPORTS_BURST_EN
                        if (bcnt_r > 8'd1) begin
                            bcnt_nx_s = bcnt_r - 8'd1;
                            addr_nx_s = (addr_r == 4'(N_OUT - 1)) ? 4'd0 : addr_r + 4'd1;
                            idx_nx_s  = NB_IDX;
                            acc_nx_s  = '0;
                        end else begin
                            state_nx_s = ST_IDLE;
                        end
`else
                        state_nx_s = ST_IDLE;
`endif
                    end else begin
                        idx_nx_s = idx_r - 3'd1;
                    end
                end else begin
                    state_nx_s = ST_WBYTE;
                end
            end
            ST_RSEND: begin
                if (ready) begin
                    dataout_nx_s = shift_r[W-1 -: 8];
                    enout_nx_s   = 1'b1;
                    state_nx_s   = ST_RWAIT;
                end else begin
                    enout_nx_s   = 1'b0;
                end
            end
            ST_RWAIT: begin
                if (ready) begin
                    enout_nx_s = 1'b1;
                end else begin
                    enout_nx_s = 1'b0;
                    if (idx_r == 3'd0) begin
                        state_nx_s = ST_IDLE;
                    end else begin
                        idx_nx_s   = idx_r - 3'd1;
                        shift_nx_s = shift_r << 8;
                        state_nx_s = ST_RSEND;
                    end
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // Control and handshake registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            addr_r    <= 4'd0;
            idx_r     <= 3'd0;
            acc_r     <= '0;
            shift_r   <= '0;
            enout_r   <= 1'b0;
            dataout_r <= 8'd0;
`ifdef IOPORTS_BURST_EN
            bcnt_r    <= 8'd0;
`endif
        end else begin
            state_r   <= state_nx_s;
            addr_r    <= addr_nx_s;
            idx_r     <= idx_nx_s;
            acc_r     <= acc_nx_s;
            shift_r   <= shift_nx_s;
            enout_r   <= enout_nx_s;
            dataout_r <= dataout_nx_s;
`ifdef IOPORTS_BURST_EN
            bcnt_r    <= bcnt_nx_s;
`endif
        end
    end

    // Output port registers and per-port pulse timers. A write reloads the
    // timer; the port clears on the timer's 1-to-0 step, so the written value
    // is visible for exactly PULSE_LEN cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_r <= INIT_OUT;
            for (int k = 0; k < N_OUT; k++) begin
                cnt_r[k] <= 8'd0;
            end
        end else begin
            for (int k = 0; k < N_OUT; k++) begin
                if (clr_s) begin
                    out_r[k*W +: W] <= INIT_OUT[k*W +: W];
                    cnt_r[k]        <= 8'd0;
                end else if (wr_s && (addr_r == 4'(k))) begin
                    out_r[k*W +: W] <= word_s;
                    cnt_r[k]        <= PULSE_MASK[k] ? PLEN : 8'd0;
                end else begin
                    if (cnt_r[k] != 8'd0) begin
                        cnt_r[k] <= cnt_r[k] - 8'd1;
                    end
                    if (PULSE_MASK[k] && (cnt_r[k] == 8'd1)) begin
                        out_r[k*W +: W] <= '0;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_ioports_param.sv
module tb_ioports_param;

    logic         clk;
    logic         reset;
    // default-parameter instance
    logic         load;
    logic [7:0]   datain;
    logic         ready;
    logic         enout;
    logic [7:0]   dataout;
    logic [255:0] in_bus;
    logic [511:0] out_bus;
    // small instance: NBYTES=1, N_OUT=4, N_IN=2, port 1 pulsed
    logic         sload;
    logic [7:0]   sdatain;
    logic         sready;
    logic         senout;
    logic [7:0]   sdataout;
    logic [15:0]  sin_bus;
    logic [31:0]  sout_bus;

    localparam logic [31:0] INIT_S = 32'hA5C3_0F5A;

    int          checks;
    int          errors;
    logic [31:0] em [16];

    ioports_param u_main (
        .clk(clk), .reset(reset), .load(load), .datain(datain), .ready(ready),
        .enout(enout), .dataout(dataout), .in_bus(in_bus), .out_bus(out_bus)
    );

    ioports_param #(
        .N_OUT(4), .N_IN(2), .NBYTES(1), .INIT_OUT(INIT_S),
        .PULSE_MASK(16'h0002), .PULSE_LEN(4)
    ) u_small (
        .clk(clk), .reset(reset), .load(sload), .datain(sdatain), .ready(sready),
        .enout(senout), .dataout(sdataout), .in_bus(sin_bus), .out_bus(sout_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [511:0] pack_main();
        logic [511:0] v;
        for (int k = 0; k < 16; k++) v[k*32 +: 32] = em[k];
        return v;
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic send(input logic [7:0] b);
        load = 1'b1; datain = b;
        @(negedge clk);
        load = 1'b0; datain = 8'h00;
    endtask

    task automatic send2(input logic [7:0] b);
        sload = 1'b1; sdatain = b;
        @(negedge clk);
        sload = 1'b0; sdatain = 8'h00;
    endtask

    task automatic send_word(input logic [7:0] cmd, input logic [31:0] w);
        send(cmd);
        send(w[31:24]); send(w[23:16]); send(w[15:8]); send(w[7:0]);
    endtask

    task automatic rd_byte(input string tag, input logic [7:0] exp, input int gap);
        for (int g = 0; g < gap; g++) begin
            tick();
            chk({tag, "_gap_enout"}, enout, 1'b0);
        end
        ready = 1'b1;
        tick();
        chk({tag, "_enout_rise"}, enout, 1'b1);
        chk({tag, "_data"}, dataout, exp);
        tick();
        chk({tag, "_enout_hold"}, enout, 1'b1);
        ready = 1'b0;
        tick();
        chk({tag, "_enout_fall"}, enout, 1'b0);
    endtask

    initial begin
        checks = 0; errors = 0;
        reset = 1'b1;
        load = 1'b0; datain = 8'h00; ready = 1'b0;
        sload = 1'b0; sdatain = 8'h00; sready = 1'b0;
        in_bus = '0;
        in_bus[3*32 +: 32] = 32'hCAFE_F00D;
        sin_bus = 16'h1234;
        for (int k = 0; k < 16; k++) em[k] = 32'h0;
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // reset state
        chk("rst_out_bus", out_bus, 512'h0);
        chk("rst_enout", enout, 1'b0);
        chk("rst_dataout", dataout, 8'h00);
        chk("rst_small_out", sout_bus, INIT_S);

        // small: write to nonexistent port 6 is discarded
        send2(8'h26); send2(8'h77);
        chk("s_wr_addr6", sout_bus, INIT_S);
        // small: write port 3
        send2(8'h23); send2(8'h3C);
        chk("s_wr_p3", sout_bus, 32'h3CC3_0F5A);
        // small: pulse port 1, rewrite at cycle 2 extends it to cycle 6
        send2(8'h21); send2(8'h11);
        chk("s_pulse_c1", sout_bus[15:8], 8'h11);
        send2(8'h21);
        chk("s_pulse_c2", sout_bus[15:8], 8'h11);
        send2(8'h22);
        chk("s_pulse_c3", sout_bus[15:8], 8'h22);
        for (int c = 4; c <= 7; c++) begin
            tick();
            chk($sformatf("s_pulse_c%0d", c), sout_bus[15:8], (c <= 6) ? 8'h22 : 8'h00);
        end
        chk("s_pulse_others", {sout_bus[31:16], sout_bus[7:0]}, 24'h3CC3_5A);
        // small: read nonexistent input port -> HWID truncated to 8 bits
        send2(8'h35);
        sready = 1'b1;
        tick();
        chk("s_rd_enout", senout, 1'b1);
        chk("s_rd_hwid", sdataout, 8'h02);
        sready = 1'b0;
        tick();
        chk("s_rd_enout_fall", senout, 1'b0);

        // main: WRITE port 2 with a load gap mid-word
        send(8'h22); send(8'h12); send(8'h34); tick(); send(8'h56); send(8'h78);
        em[2] = 32'h1234_5678;
        chk("wr_p2", out_bus, pack_main());

        // main: pulse port 15, WRITE port 3 issued during the pulse
        send_word(8'h2F, 32'h0000_0001);
        chk("pulse_c1", out_bus[15*32 +: 32], 32'h1);
        send(8'h23);
        chk("pulse_c2", out_bus[15*32 +: 32], 32'h1);
        send(8'hAA);
        chk("pulse_c3", out_bus[15*32 +: 32], 32'h1);
        send(8'hBB);
        chk("pulse_c4", out_bus[15*32 +: 32], 32'h1);
        send(8'hCC);
        chk("pulse_c5", out_bus[15*32 +: 32], 32'h0);
        send(8'hDD);
        em[3] = 32'hAABB_CCDD;
        chk("wr_p3_during_pulse", out_bus, pack_main());

        // main: READ port 3; snapshot taken when the command is accepted
        send(8'h33);
        in_bus[3*32 +: 32] = 32'h0BAD_BEEF;
        rd_byte("rd3_b0", 8'hCA, $urandom_range(0, 3));
        rd_byte("rd3_b1", 8'hFE, $urandom_range(0, 3));
        rd_byte("rd3_b2", 8'hF0, $urandom_range(0, 3));
        rd_byte("rd3_b3", 8'h0D, $urandom_range(0, 3));
        // main: READ nonexistent input port 9 -> HWID
        send(8'h39);
        rd_byte("rd9_b0", 8'h20, 1);
        rd_byte("rd9_b1", 8'h18, 0);
        rd_byte("rd9_b2", 8'h17, 2);
        rd_byte("rd9_b3", 8'h02, 0);

        // main: BURST start 14, count 3 (bytes are harmless opcodes when absent)
        send(8'h4E); send(8'h03);
        send(8'h0A); send(8'h0B); send(8'h0C); send(8'h0D);
        send(8'h5A); send(8'h5B); send(8'h5C); send(8'h5D);
`ifdef IOPORTS_BURST_EN
        chk("burst_p15_pulse", out_bus[15*32 +: 32], 32'h5A5B_5C5D);
`else
        chk("burst_p15_pulse", out_bus[15*32 +: 32], 32'h0);
`endif
        send(8'hE1); send(8'hF2); send(8'h6D); send(8'h7C);
`ifdef IOPORTS_BURST_EN
        em[14] = 32'h0A0B_0C0D;
        em[0]  = 32'hE1F2_6D7C;
`endif
        chk("burst_result", out_bus, pack_main());
        // main: BURST with count 0 transfers one word
        send(8'h41); send(8'h00);
        send(8'h0F); send(8'h0E); send(8'h0D); send(8'h0C);
`ifdef IOPORTS_BURST_EN
        em[1] = 32'h0F0E_0D0C;
`endif
        chk("burst_c0", out_bus, pack_main());

        // reset mid-WRITE after two data bytes
        send(8'h24); send(8'h11); send(8'h22);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int k = 0; k < 16; k++) em[k] = 32'h0;
        chk("midrst_bus", out_bus, pack_main());
        chk("midrst_enout", enout, 1'b0);
        chk("midrst_small", sout_bus, INIT_S);
        send_word(8'h25, 32'h0102_0304);
        em[5] = 32'h0102_0304;
        chk("post_rst_wr", out_bus, pack_main());

        // RESET command clears an in-flight pulse immediately
        send_word(8'h2F, 32'h0000_0099);
        chk("rcmd_pulse_on", out_bus[15*32 +: 32], 32'h99);
        send(8'h10);
        em[5] = 32'h0;
        chk("rcmd_clear", out_bus, pack_main());
        repeat (4) tick();
        chk("rcmd_stays", out_bus, pack_main());

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ioports_param.md
# ioports_param

Parametrised general-purpose I/O port bank driven by the 8-bit byte-serial host command link. It generalises the fixed 32-bit, 8-in/16-out port block in four ways: configurable port width, configurable port counts, per-port auto-return-to-zero with independent concurrent pulse timers, and an optional burst-write command. It sits between the host link controller (load/datain, ready/enout/dataout) and the datapath registers it configures and observes.

## Interface
- `N_OUT`, 16: number of output ports, 1..16.
- `N_IN`, 8: number of input ports, 1..16.
- `NBYTES`, 4: bytes per port, 1..8. Port width W = 8*NBYTES.
- `INIT_OUT`, 0: flat N_OUT*W reset/RESET-command value. Port k is bits [k*W +: W].
- `PULSE_MASK`, 16'h8000: bit k=1 makes output port k auto-return-to-zero.
- `PULSE_LEN`, 4: cycles a written value is held on a pulse port, 1..255.
- `HWID`, 32'h2018_1702: value returned for reads of nonexistent input ports, zero-extended or truncated to W.

Ports:
- `clk` in 1: master clock. Single clock domain.
- `reset` in 1: synchronous, active-high master reset.
- `load` in 1: datain valid, one byte per cycle while high.
- `datain` in 8: command/data byte.
- `ready` in 1: host ready to take a dataout byte.
- `enout` out 1: dataout valid.
- `dataout` out 8: read data byte.
- `in_bus` in N_IN*W: input ports, port k at [k*W +: W].
- `out_bus` out N_OUT*W: output port registers.

## Operation
- Reset values: out_bus=INIT_OUT, enout=0, dataout=0, all pulse counters=0, state IDLE.
- Command byte, accepted in IDLE with load=1: opcode datain[6:4], address datain[3:0].
  - 001 RESET: out_bus<=INIT_OUT, counters cleared, enout<=0. Stay IDLE.
  - 010 WRITE: latch addr, then go to WBYTE with byte index NBYTES-1.
  - 011 READ: snapshot the addressed input port (HWID if addr>=N_IN) into the shift register, then go to RSEND with index NBYTES-1.
  - 100 BURST (only with the macro): latch start addr, then go to WCOUNT.
  - Any other opcode: ignored, stay IDLE.
- WCOUNT: the next load byte is the port count C. C=0 is treated as 1. Go to WBYTE.
- WBYTE: bytes arrive MS first and are accumulated; cycles with load=0 wait indefinitely.
  - On the LS byte, the full word is written to port addr.
  - If addr>=N_OUT, the bytes are consumed and discarded.
  - In BURST, addr increments after each word and wraps N_OUT-1 to 0. Return to IDLE after C words.
- Pulse ports (PULSE_MASK[k]=1):
  - Every write to port k loads counter k with PULSE_LEN. A rewrite during a pulse reloads the counter.
  - Counters decrement every cycle, independently of the FSM.
  - On the 1-to-0 transition the port is cleared to 0. The value is visible for exactly PULSE_LEN cycles.
  - Pulses do not block new commands.
- Read handshake:
  - RSEND: when ready=1, dataout<=current byte, enout<=1, go to RWAIT. While ready=0, enout<=0 and wait.
  - RWAIT: while ready=1, hold enout=1. On ready=0, enout<=0. If index=0 go to IDLE, else decrement index and go to RSEND.
  - Bytes are sent MS first.
- FSM states: IDLE, WCOUNT, WBYTE, RSEND, RWAIT. Any undefined encoding goes to IDLE.
- `reset` mid-command aborts any transfer and restores all reset values in the same edge.

## Timing
- Write: out_bus updates on the clock edge that samples the LS byte with load=1. Visible the next cycle.
- Pulse: the port reads the written value in cycles 1..PULSE_LEN after that edge and reads 0 from cycle PULSE_LEN+1.
- Read snapshot: taken on the edge that accepts the command byte.
- enout: rises one cycle after ready is sampled high and falls one cycle after ready is sampled low.
- A command byte presented in the same cycle the FSM returns to IDLE is not seen. The host must present it in a later cycle.
- No combinational path from inputs to outputs; all outputs are registered.

## Configuration
- `IOPORTS_BURST_EN` defined: opcode 100 and state WCOUNT are implemented.
- Not defined: opcode 100 is ignored like any unknown opcode, WCOUNT is absent, and no burst address-increment logic is built.

## Test plan
- Reset, then WRITE port 2 with bytes 12,34,56,78 (NBYTES=4) -> port 2 = 32'h12345678; all other ports stay at INIT_OUT.
- WRITE port 15 = 32'h1 with PULSE_LEN=4 -> port 15 = 1 for exactly 4 cycles then 0. A rewrite at cycle 2 extends the pulse to cycle 6; a WRITE to port 3 issued during the pulse completes normally.
- in3=32'hCAFEF00D, READ port 3, ready toggled with random gaps -> dataout sequence CA,FE,F0,0D, one enout pulse per ready pulse. READ port 9 with N_IN=8 -> 20,18,17,02.
- BURST start=14, C=3, N_OUT=16 -> ports 14, 15, 0 written in order; port 15 pulses. Without the macro, the same stimulus leaves all ports unchanged and the data bytes are decoded as commands.
- Assert reset mid-WRITE after 2 bytes -> outputs return to INIT_OUT and the next command decodes cleanly. The RESET command clears an in-flight pulse immediately.
- NBYTES=1, N_OUT=4: WRITE addr 6 -> byte discarded, no port changes.
